// File: rtl/fixed_vit_sched_pkg.sv
// rtl/fixed_vit_sched_pkg.sv - shared types and round-robin pick function for the ViT parameter arbiter
package fixed_vit_sched_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    localparam int unsigned RR_MAX_REQ = 32;
    localparam int unsigned RR_IDX_W   = 5;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] index;
    } rr_pick_t;

    // First set request bit scanning upward from last+1, wrapping at num_req.
    function automatic rr_pick_t rr_next(
        input logic [RR_MAX_REQ-1:0] req,
        input logic [RR_IDX_W-1:0]   last,
        input int unsigned           num_req
    );
        rr_pick_t          pick;
        logic [RR_IDX_W:0] cand;
        pick = '0;
        for (int unsigned k = 1; k <= RR_MAX_REQ; k++) begin
            if (k <= num_req) begin
                cand = {1'b0, last} + (RR_IDX_W+1)'(k);
                if (cand >= (RR_IDX_W+1)'(num_req)) begin
                    cand = cand - (RR_IDX_W+1)'(num_req);
                end
                if (!pick.found && req[RR_IDX_W'(cand)]) begin
                    pick.found = 1'b1;
                    pick.index = RR_IDX_W'(cand);
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/skid_buffer.sv
// rtl/skid_buffer.sv - 2-entry registered skid buffer; s_tready depends only on fill state
module skid_buffer #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready
);

    logic [1:0]            count_q, count_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic                  push, pop;

    assign s_tready = (count_q != 2'd2);
    assign m_tvalid = (count_q != 2'd0);
    assign m_tdata  = head_q;
    assign push     = s_tvalid & s_tready;
    assign pop      = m_tvalid & m_tready;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) head_d = s_tdata;
                else                 tail_d = s_tdata;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            // Simultaneous push and pop only happens with exactly one entry held.
            2'b11: head_d = s_tdata;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

// File: rtl/fixed_vit_param_arbiter.sv
// rtl/fixed_vit_param_arbiter.sv - round-robin burst arbiter for ViT parameter streams (optional FIXED_VIT_PARAM_ARB_SKID_EN)
module fixed_vit_param_arbiter
    import fixed_vit_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned BURST_LEN  = 8,
    parameter int unsigned SEL_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    output logic [NUM_REQ-1:0]    grant,
    output logic [SEL_WIDTH-1:0]  src_sel,
    input  logic [DATA_WIDTH-1:0] src_data,
    input  logic                  src_valid,
    output logic                  src_ready,
    output logic [DATA_WIDTH-1:0] dst_data,
    output logic [NUM_REQ-1:0]    dst_valid,
    input  logic [NUM_REQ-1:0]    dst_ready,
    output logic                  busy
);

    localparam int unsigned          CNT_W    = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [SEL_WIDTH-1:0] LAST_RST = SEL_WIDTH'(NUM_REQ - 1);

    arb_state_e             state_q, state_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [SEL_WIDTH-1:0]   sel_q, sel_d;
    logic [SEL_WIDTH-1:0]   last_q, last_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic [RR_MAX_REQ-1:0]  req_ext;
    rr_pick_t               pick;
    logic [SEL_WIDTH-1:0]   pick_sel;
    logic                   in_burst;
    logic                   owner_ready;
    logic                   fwd_valid;
    logic [DATA_WIDTH-1:0]  fwd_data;
    logic                   dst_hs;
    logic                   burst_done;

    always_comb begin
        req_ext               = '0;
        req_ext[NUM_REQ-1:0]  = req;
        pick                  = rr_next(req_ext, RR_IDX_W'(last_q), NUM_REQ);
        pick_sel              = SEL_WIDTH'(pick.index);
    end

    assign in_burst    = (state_q == ST_BURST);
    assign owner_ready = dst_ready[sel_q];
    assign dst_hs      = in_burst & fwd_valid & owner_ready;
    assign burst_done  = dst_hs & (cnt_q == CNT_LAST);

`ifdef FIXED_VIT_PARAM_ARB_SKID_EN
    // Source side is throttled only by buffer fill and the per-burst accept count.
    logic [CNT_W-1:0]      acc_q, acc_d;
    logic                  src_open;
    logic                  sb_s_valid, sb_s_ready;
    logic                  sb_m_valid, sb_m_ready;
    logic [DATA_WIDTH-1:0] sb_m_data;

    assign src_open   = in_burst & (acc_q != CNT_W'(BURST_LEN));
    assign sb_s_valid = src_valid & src_open;
    assign sb_m_ready = in_burst & owner_ready;

    skid_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst),
        .s_tdata  (src_data),
        .s_tvalid (sb_s_valid),
        .s_tready (sb_s_ready),
        .m_tdata  (sb_m_data),
        .m_tvalid (sb_m_valid),
        .m_tready (sb_m_ready)
    );

    always_comb begin
        acc_d = acc_q;
        if (burst_done) begin
            acc_d = '0;
        end else if (sb_s_valid & sb_s_ready) begin
            acc_d = acc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) acc_q <= '0;
        else      acc_q <= acc_d;
    end

    assign fwd_valid = sb_m_valid;
    assign fwd_data  = sb_m_data;
`else
    assign fwd_valid = src_valid;
    assign fwd_data  = src_data;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick.found) begin
                    state_d = ST_BURST;
                    grant_d = NUM_REQ'(1) << pick_sel;
                    sel_d   = pick_sel;
                end
            end
            ST_BURST: begin
                if (burst_done) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    last_d  = sel_q;
                    cnt_d   = '0;
                end else if (dst_hs) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = in_burst;
        dst_valid = grant_q & {NUM_REQ{in_burst & fwd_valid}};
        dst_data  = in_burst ? fwd_data : '0;
`ifdef FIXED_VIT_PARAM_ARB_SKID_EN
        src_ready = src_open & sb_s_ready;
`else
        src_ready = in_burst & owner_ready;
`endif
    end

    assign grant   = grant_q;
    assign src_sel = sel_q;

endmodule
